syn_interrupt_controller: RTL

SYN_INTERRUPT_CONTROLLER -- requirements
Module: syn_interrupt_controller

---
 rtl/syn_interrupt_controller_if.sv | 30 +++
 rtl/syn_interrupt_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/syn_interrupt_controller_if.sv
// Bus bundle between the interrupt controller and the surrounding pipeline/PC logic.
interface syn_interrupt_controller_if #(
  parameter int IM_ADDR_BIT = 12
);
  logic                   en;
  logic [2:0]             irq_in;
  logic                   mask_w_en;
  logic [2:0]             mask_in;
  logic                   stall;
  logic                   int_ack;
  logic [IM_ADDR_BIT-1:0] pc_resume;
  logic                   eret;
  logic                   int_req;
  logic [IM_ADDR_BIT-1:0] int_addr;
  logic [IM_ADDR_BIT-1:0] epc;
  logic [1:0]             int_id;
  logic                   in_service;
  logic [2:0]             pending;
  logic [2:0]             mask;

  modport master (
    output en, irq_in, mask_w_en, mask_in, stall, int_ack, pc_resume, eret,
    input  int_req, int_addr, epc, int_id, in_service, pending, mask
  );

  modport slave (
    input  en, irq_in, mask_w_en, mask_in, stall, int_ack, pc_resume, eret,
    output int_req, int_addr, epc, int_id, in_service, pending, mask
  );
endinterface

// File: rtl/syn_interrupt_controller.sv
// Three-source vectored interrupt controller with edge-detected requests and a return stack.
// Define INT_NESTED_EN for preemption by strictly higher-priority sources (stack depth 3).
module syn_interrupt_controller #(
  parameter int                     IM_ADDR_BIT = 12,
  parameter logic [IM_ADDR_BIT-1:0] VEC0        = 12'h100,
  parameter logic [IM_ADDR_BIT-1:0] VEC1        = 12'h140,
  parameter logic [IM_ADDR_BIT-1:0] VEC2        = 12'h180
) (
  input logic                      clk,
  input logic                      rst,
  syn_interrupt_controller_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ID_NONE = 2'd3;

  state_t                 state_r;
  logic [2:0]             irq_q_r;
  logic [2:0]             pending_r;
  logic [2:0]             mask_r;
  logic [1:0]             sel_r;
  logic                   int_req_r;
  logic [IM_ADDR_BIT-1:0] int_addr_r;
  logic [IM_ADDR_BIT-1:0] epc_r;
  logic [1:0]             int_id_r;
  logic                   in_service_r;

  logic [2:0]             eligible_s;
  logic [1:0]             hi_sel_s;
  logic [2:0]             set_s;
  logic [2:0]             clr_s;
  logic [2:0]             pending_nxt_s;

`ifdef INT_NESTED_EN
  logic [IM_ADDR_BIT-1:0] stk_pc_r [0:2];
  logic [1:0]             stk_id_r [0:2];
  logic [1:0]             sp_r;
  logic                   preempt_s;
`endif

  // Fixed priority: lowest index wins, ID_NONE when nothing is eligible.
  function automatic logic [1:0] prio_sel(input logic [2:0] vec);
    logic [1:0] id;
    if (vec[0]) begin
      id = 2'd0;
    end else if (vec[1]) begin
      id = 2'd1;
    end else if (vec[2]) begin
      id = 2'd2;
    end else begin
      id = ID_NONE;
    end
    return id;
  endfunction

  function automatic logic [IM_ADDR_BIT-1:0] vec_of(input logic [1:0] id);
    logic [IM_ADDR_BIT-1:0] addr;
    case (id)
      2'd0:    addr = VEC0;
      2'd1:    addr = VEC1;
      2'd2:    addr = VEC2;
      default: addr = {IM_ADDR_BIT{1'b0}};
    endcase
    return addr;
  endfunction

  // Edge detection, arbitration and pending next-state (a new edge beats the ack clear).
  always_comb begin
    eligible_s = pending_r & ~mask_r;
    hi_sel_s   = prio_sel(eligible_s);
    set_s      = bus.irq_in & ~irq_q_r;
    if ((state_r == S_REQ) && bus.int_ack) begin
      clr_s = 3'b001 << sel_r;
    end else begin
      clr_s = 3'b000;
    end
    pending_nxt_s = (pending_r & ~clr_s) | set_s;
  end

`ifdef INT_NESTED_EN
  // Preemption only by a strictly more urgent source than the one being serviced.
  always_comb begin
    if ((state_r == S_SERVICE) && (eligible_s != 3'b000) && !bus.stall &&
        (hi_sel_s < int_id_r) && (sp_r != 2'd3)) begin
      preempt_s = 1'b1;
    end else begin
      preempt_s = 1'b0;
    end
  end
`endif

  // Controller state, return stack and registered outputs; en low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      irq_q_r      <= 3'b000;
      pending_r    <= 3'b000;
      mask_r       <= 3'b000;
      sel_r        <= ID_NONE;
      int_req_r    <= 1'b0;
      int_addr_r   <= {IM_ADDR_BIT{1'b0}};
      epc_r        <= {IM_ADDR_BIT{1'b0}};
      int_id_r     <= ID_NONE;
      in_service_r <= 1'b0;
`ifdef INT_NESTED_EN
      sp_r         <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        stk_pc_r[i] <= {IM_ADDR_BIT{1'b0}};
        stk_id_r[i] <= ID_NONE;
      end
`endif
    end else if (bus.en) begin
      irq_q_r   <= bus.irq_in;
      pending_r <= pending_nxt_s;
      if (bus.mask_w_en) begin
        mask_r <= bus.mask_in;
      end else begin
        mask_r <= mask_r;
      end
      case (state_r)
        S_IDLE: begin
          if ((eligible_s != 3'b000) && !bus.stall) begin
            state_r    <= S_REQ;
            sel_r      <= hi_sel_s;
            int_req_r  <= 1'b1;
            int_addr_r <= vec_of(hi_sel_s);
            int_id_r   <= hi_sel_s;
          end
        end
        S_REQ: begin
          // The latched request stands until acknowledged, whatever the mask does.
          if (bus.int_ack) begin
            state_r      <= S_SERVICE;
            int_req_r    <= 1'b0;
            in_service_r <= 1'b1;
            epc_r        <= bus.pc_resume;
`ifdef INT_NESTED_EN
            stk_pc_r[sp_r] <= bus.pc_resume;
            stk_id_r[sp_r] <= sel_r;
            sp_r           <= sp_r + 2'd1;
`endif
          end
        end
        S_SERVICE: begin
`ifdef INT_NESTED_EN
          if (bus.eret && (sp_r > 2'd1)) begin
            sp_r       <= sp_r - 2'd1;
            epc_r      <= stk_pc_r[sp_r - 2'd2];
            int_id_r   <= stk_id_r[sp_r - 2'd2];
            sel_r      <= stk_id_r[sp_r - 2'd2];
            int_addr_r <= vec_of(stk_id_r[sp_r - 2'd2]);
          end else if (bus.eret) begin
            sp_r         <= 2'd0;
            state_r      <= S_IDLE;
            in_service_r <= 1'b0;
            epc_r        <= {IM_ADDR_BIT{1'b0}};
            int_id_r     <= ID_NONE;
            int_addr_r   <= {IM_ADDR_BIT{1'b0}};
          end else if (preempt_s) begin
            state_r      <= S_REQ;
            sel_r        <= hi_sel_s;
            int_req_r    <= 1'b1;
            in_service_r <= 1'b0;
            int_addr_r   <= vec_of(hi_sel_s);
            int_id_r     <= hi_sel_s;
          end
`else
          if (bus.eret) begin
            state_r      <= S_IDLE;
            in_service_r <= 1'b0;
            epc_r        <= {IM_ADDR_BIT{1'b0}};
            int_id_r     <= ID_NONE;
            int_addr_r   <= {IM_ADDR_BIT{1'b0}};
          end
`endif
        end
        default: begin
          state_r      <= S_IDLE;
          int_req_r    <= 1'b0;
          in_service_r <= 1'b0;
          int_id_r     <= ID_NONE;
        end
      endcase
    end
  end

  assign bus.int_req    = int_req_r;
  assign bus.int_addr   = int_addr_r;
  assign bus.epc        = epc_r;
  assign bus.int_id     = int_id_r;
  assign bus.in_service = in_service_r;
  assign bus.pending    = pending_r;
  assign bus.mask       = mask_r;

endmodule
